// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_sequencer controller.
// Holds the opcode constants, the controller state encoding and the
// bit positions of the fields inside a 16-bit instruction word.
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Instruction field positions: [15:12] opcode, [11:8] A, [7:4] B, [3:0] reserved
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 4;
  localparam int RSV_MSB = 3;
  localparam int RSV_LSB = 0;

  localparam logic [3:0] OP_NON = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 4-bit add/sub ALU.
// Fetches 16-bit instructions from a 2**ADDR_W entry memory, drives the ALU
// for one cycle per ADD/SUB, and offers the ALU result on a valid/ready port.
// Stops on HLT, on an illegal opcode (sticky err) or after the last address.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   start                    begin at pc=0 (only from IDLE or HALT)
//   imem_en/imem_addr        instruction memory read request
//   imem_data                instruction, valid the cycle after imem_en
//   alu_opcode/alu_a/alu_b   ALU command, opcode is NON outside EXEC
//   alu_result               registered ALU output
//   result/result_valid      result port; result_ready accepts it
//   busy, done, err          status: running, halted, illegal opcode seen
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [3:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic [INSTR_W-1:0]  ir, ir_next;
  logic [DATA_W-1:0]   result_q, result_next;
  logic                wb_hold, wb_hold_next;
  logic                err_next;

  // The reserved instruction bits carry no meaning for this controller.
  logic reserved_unused;
  assign reserved_unused = ^ir[RSV_MSB:RSV_LSB];

  assign imem_addr = pc;
  assign alu_a     = ir[A_LSB +: DATA_W];
  assign alu_b     = ir[B_LSB +: DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      result_q <= '0;
      wb_hold  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir       <= ir_next;
      result_q <= result_next;
      wb_hold  <= wb_hold_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    result_next  = result_q;
    wb_hold_next = wb_hold;
    err_next     = err;
    imem_en      = 1'b0;
    alu_opcode   = OP_NON;
    result       = result_q;
    result_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_en    = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        ir_next = imem_data;
        case (imem_data[OP_MSB:OP_LSB])
          OP_HLT: state_next = S_HALT;
          OP_ADD, OP_SUB: state_next = S_EXEC;
          OP_NON: begin
            if (pc == PC_LAST) begin
              state_next = S_HALT;
            end else begin
              pc_next    = pc + ADDR_W'(1);
              state_next = S_FETCH;
            end
          end
          default: begin
            err_next   = 1'b1;
            state_next = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        alu_opcode = ir[OP_MSB:OP_LSB];
        state_next = S_WB;
      end

      // The ALU result is visible in the first WB cycle, so it is passed
      // straight through then and captured; later stall cycles replay the
      // captured copy so the port stays stable while the ALU moves on.
      S_WB: begin
        result_valid = 1'b1;
        if (!wb_hold) begin
          result      = alu_result;
          result_next = alu_result;
        end
        if (result_ready) begin
          wb_hold_next = 1'b0;
          if (pc == PC_LAST) begin
            state_next = S_HALT;
          end else begin
            pc_next    = pc + ADDR_W'(1);
            state_next = S_FETCH;
          end
        end else begin
          wb_hold_next = 1'b1;
        end
      end

      S_HALT: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          err_next   = 1'b0;
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer.
// Surrounds the controller with a registered instruction memory and a
// registered add/sub ALU, and compares the emitted results, fetch addresses
// and status flags against a program-level reference model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        result_ready = 1'b0;
  logic        imem_en;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_result = '0;
  logic [3:0]  result;
  logic        result_valid;
  logic        busy;
  logic        done;
  logic        err;

  int check_count = 0;
  int pass_count  = 0;
  bit rand_ready  = 1'b0;

  logic [15:0] mem [16];
  logic [3:0]  got_q [$];
  int          fetch_q [$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [3:0]  prev_result = '0;

  typedef struct {
    logic [15:0] instr;
    int          n_res;
    logic [3:0]  res;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  cpu_sequencer #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Registered instruction memory and registered ALU around the controller.
  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
  end

  always @(posedge clk) begin
    case (alu_opcode)
      4'h1: alu_result <= alu_a + alu_b;
      4'h2: alu_result <= alu_a - alu_b;
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Observer: records accepted results and fetch addresses, and checks that
  // a stalled result does not change while it waits for result_ready.
  always @(negedge clk) begin
    if (rst) begin
      if (result_valid && prev_valid && !prev_ready)
        checkOutput("hold_result", int'(result), int'(prev_result));
      if (result_valid && result_ready) got_q.push_back(result);
      if (imem_en) fetch_q.push_back(int'(imem_addr));
    end
    prev_valid  = rst && result_valid;
    prev_ready  = result_ready;
    prev_result = result;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) result_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setReady(input logic v);
    @(posedge clk);
    #1 result_ready = v;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic loadFill(input logic [15:0] fill);
    for (int i = 0; i < 16; i++) mem[i] = fill;
  endtask

  task automatic clearQueues();
    got_q.delete();
    fetch_q.delete();
  endtask

  // Leaves the caller at the negedge of the first FETCH cycle.
  task automatic startPulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input bit pulse_mid);
    int cyc = 0;
    while (cyc < 1000 && !done) begin
      start = (pulse_mid && busy && (cyc % 3 == 0)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("reach_halt", int'(done), 1);
  endtask

  // Program-level model: walk the memory from address 0 applying the
  // opcode rules, collecting results, fetched addresses and the error flag.
  task automatic compareModel(input string tag);
    int exp_res [$];
    int exp_fetch [$];
    int exp_err = 0;
    for (int pc = 0; pc < 16; pc++) begin
      int op, a, b;
      op = int'(mem[pc][15:12]);
      a  = int'(mem[pc][11:8]);
      b  = int'(mem[pc][7:4]);
      exp_fetch.push_back(pc);
      if (op == 15) break;
      if (op == 1) exp_res.push_back((a + b) % 16);
      else if (op == 2) exp_res.push_back((a - b + 16) % 16);
      else if (op != 0) begin
        exp_err = 1;
        break;
      end
    end
    checkOutput({tag, "_nres"}, got_q.size(), exp_res.size());
    for (int i = 0; i < got_q.size() && i < exp_res.size(); i++)
      checkOutput({tag, "_res"}, int'(got_q[i]), exp_res[i]);
    checkOutput({tag, "_nfetch"}, fetch_q.size(), exp_fetch.size());
    for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++)
      checkOutput({tag, "_fetch"}, fetch_q[i], exp_fetch[i]);
    checkOutput({tag, "_err"}, int'(err), exp_err);
    checkOutput({tag, "_done"}, int'(done), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic applyStimulus(input string tag, input bit pulse_mid);
    clearQueues();
    startPulse();
    waitDone(pulse_mid);
    compareModel(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_imem_en"}, int'(imem_en), 0);
    checkOutput({tag, "_imem_addr"}, int'(imem_addr), 0);
    checkOutput({tag, "_alu_opcode"}, int'(alu_opcode), 0);
    checkOutput({tag, "_alu_a"}, int'(alu_a), 0);
    checkOutput({tag, "_alu_b"}, int'(alu_b), 0);
    checkOutput({tag, "_result"}, int'(result), 0);
    checkOutput({tag, "_valid"}, int'(result_valid), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
  endtask

  task automatic loadBasicProgram();
    loadFill(16'hF000);
    mem[0] = 16'h1340;
    mem[1] = 16'h2250;
    mem[2] = 16'h0000;
    mem[3] = 16'hF000;
  endtask

  initial begin
    vecs[0] = '{16'h1340, 1, 4'h7, 1'b0};
    vecs[1] = '{16'h2250, 1, 4'hD, 1'b0};
    vecs[2] = '{16'h1F10, 1, 4'h0, 1'b0};
    vecs[3] = '{16'h2010, 1, 4'hF, 1'b0};
    vecs[4] = '{16'h178F, 1, 4'hF, 1'b0};
    vecs[5] = '{16'h2A30, 1, 4'h7, 1'b0};
    vecs[6] = '{16'h0000, 0, 4'h0, 1'b0};
    vecs[7] = '{16'h5000, 0, 4'h0, 1'b1};
    vecs[8] = '{16'hE000, 0, 4'h0, 1'b1};
    vecs[9] = '{16'hF000, 0, 4'h0, 1'b0};
    loadFill(16'hF000);

    // Reset values, then IDLE until start.
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    repeat (3) step();
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_imem_en", int'(imem_en), 0);

    // Basic program with ready high: cycle-level latency then full compare.
    $display("[TB] basic program");
    loadBasicProgram();
    setReady(1'b1);
    clearQueues();
    startPulse();
    checkOutput("t1_fetch0_en", int'(imem_en), 1);
    checkOutput("t1_fetch0_addr", int'(imem_addr), 0);
    checkOutput("t1_fetch0_busy", int'(busy), 1);
    step();
    checkOutput("t1_decode_valid", int'(result_valid), 0);
    step();
    checkOutput("t1_exec_op", int'(alu_opcode), 1);
    checkOutput("t1_exec_a", int'(alu_a), 3);
    checkOutput("t1_exec_b", int'(alu_b), 4);
    step();
    checkOutput("t1_wb_valid", int'(result_valid), 1);
    checkOutput("t1_wb_result", int'(result), 7);
    step();
    checkOutput("t1_fetch1_en", int'(imem_en), 1);
    checkOutput("t1_fetch1_addr", int'(imem_addr), 1);
    waitDone(1'b0);
    compareModel("t1");
    checkOutput("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      checkOutput("t1_first", int'(got_q[0]), 7);
      checkOutput("t1_second", int'(got_q[1]), 13);
    end

    // Stall the first result for five cycles.
    $display("[TB] stalled result");
    setReady(1'b0);
    clearQueues();
    startPulse();
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_stall_valid", int'(result_valid), 1);
      checkOutput("t2_stall_result", int'(result), 7);
      checkOutput("t2_stall_no_fetch", int'(imem_en), 0);
      if (i < 4) step();
    end
    setReady(1'b1);
    step();
    checkOutput("t2_hs_valid", int'(result_valid), 1);
    step();
    checkOutput("t2_fetch1_en", int'(imem_en), 1);
    checkOutput("t2_fetch1_addr", int'(imem_addr), 1);
    waitDone(1'b0);
    compareModel("t2");

    // Wrapping add followed by an illegal opcode, then restart clears err.
    $display("[TB] illegal opcode");
    loadFill(16'hF000);
    mem[0] = 16'h1F10;
    mem[1] = 16'h5000;
    applyStimulus("t3", 1'b0);
    checkOutput("t3_err", int'(err), 1);
    checkOutput("t3_count", got_q.size(), 1);
    if (got_q.size() == 1) checkOutput("t3_wrap", int'(got_q[0]), 0);
    clearQueues();
    startPulse();
    checkOutput("t3_restart_err", int'(err), 0);
    checkOutput("t3_restart_en", int'(imem_en), 1);
    checkOutput("t3_restart_addr", int'(imem_addr), 0);
    waitDone(1'b0);
    compareModel("t3r");

    // Full memory of ADD 1,1 with no HLT: runs off the end without wrapping.
    $display("[TB] end of memory");
    loadFill(16'h1110);
    applyStimulus("t4", 1'b0);
    checkOutput("t4_count", got_q.size(), 16);
    foreach (got_q[i]) checkOutput("t4_value", int'(got_q[i]), 2);
    checkOutput("t4_err", int'(err), 0);
    repeat (3) step();
    checkOutput("t4_no_wrap_fetch", int'(imem_en), 0);
    checkOutput("t4_still_done", int'(done), 1);

    // Start pulses while busy are ignored.
    $display("[TB] start while busy");
    applyStimulus("t6", 1'b1);
    checkOutput("t6_count", got_q.size(), 16);

    // Single-instruction table.
    $display("[TB] instruction table");
    for (int v = 0; v < 10; v++) begin
      loadFill(16'hF000);
      mem[0] = vecs[v].instr;
      applyStimulus("tbl", 1'b0);
      checkOutput("tbl_nres", got_q.size(), vecs[v].n_res);
      if (vecs[v].n_res > 0 && got_q.size() > 0)
        checkOutput("tbl_res", int'(got_q[0]), int'(vecs[v].res));
      checkOutput("tbl_err", int'(err), int'(vecs[v].exp_err));
    end

    // Random programs with random ready, half with start pulses mid-run.
    $display("[TB] random programs");
    rand_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        int sel;
        logic [3:0] op;
        sel = int'($urandom_range(0, 31));
        if (sel < 12) op = 4'h1;
        else if (sel < 22) op = 4'h2;
        else if (sel < 27) op = 4'h0;
        else if (sel == 27) op = 4'hF;
        else if (sel == 28) op = 4'($urandom_range(3, 14));
        else op = 4'h1;
        mem[i] = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15))};
      end
      applyStimulus("rnd", r[0]);
    end
    rand_ready = 1'b0;

    // Asynchronous reset while a result is waiting.
    $display("[TB] reset during write-back");
    loadBasicProgram();
    setReady(1'b0);
    clearQueues();
    startPulse();
    repeat (3) step();
    checkOutput("t5_pre_valid", int'(result_valid), 1);
    #2 rst = 1'b0;
    #1 checkResetOutputs("t5_async");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    checkOutput("t5_idle_busy", int'(busy), 0);
    checkOutput("t5_idle_done", int'(done), 0);
    checkOutput("t5_idle_en", int'(imem_en), 0);
    setReady(1'b1);
    applyStimulus("t5r", 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller that sequences the 4-bit add/sub ALU datapath from a 16-entry instruction memory.
- Each step fetches a 16-bit instruction, drives opcode and operands to the ALU for one cycle, and captures the registered ALU result.
- Presents the result on a valid/ready output port and stops on HLT, on an illegal opcode or at end of program memory.

Parameters:
ADDR_W, 4, instruction memory address width (program depth 2**ADDR_W)
DATA_W, 4, operand/result width; must match the ALU

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  begin execution at pc=0; honoured only in IDLE or HALT
imem_en  out  1  instruction memory read enable
imem_addr  out  ADDR_W  instruction memory address
imem_data  in  16  instruction; valid the cycle after imem_en
alu_opcode  out  4  opcode to ALU
alu_a  out  DATA_W  operand A to ALU
alu_b  out  DATA_W  operand B to ALU
alu_result  in  DATA_W  ALU registered output (updated at posedge after alu_opcode driven)
result  out  DATA_W  captured result
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
busy  out  1  high in any state other than IDLE/HALT
done  out  1  high while in HALT
err  out  1  sticky illegal-opcode flag

Behaviour:
- Instruction format: [15:12] opcode, [11:8] A, [7:4] B, [3:0] reserved (ignored).
- Opcodes: NON=4'h0, ADD=4'h1, SUB=4'h2, HLT=4'hF; all others illegal.
- Reset (async, rst=0): state=IDLE, pc=0, ir=0; outputs imem_en=0, imem_addr=0, alu_opcode=NON, alu_a=0, alu_b=0, result=0, result_valid=0, busy=0, done=0, err=0. Reset mid-instruction abandons it; no result is emitted.
- States and transitions:
  - IDLE: start -> pc=0, FETCH.
  - FETCH: imem_en=1, imem_addr=pc -> DECODE.
  - DECODE: ir<=imem_data. HLT -> HALT. Illegal -> err<=1, HALT. NON -> pc advance (see below). ADD/SUB -> EXEC.
  - EXEC: alu_opcode=ir[15:12], alu_a=ir[11:8], alu_b=ir[7:4] for exactly one cycle -> WB.
  - WB: in the first WB cycle, result<=alu_result and result_valid<=1. Hold result and valid stable until result_ready=1. On the handshake cycle, result_valid<=0 and pc advances.
  - HALT: done=1. start -> err<=0, pc=0, FETCH.
- Outside EXEC, alu_opcode=NON; alu_a and alu_b hold ir fields.
- pc advance: if pc==2**ADDR_W-1, go to HALT (done, err unchanged, no wrap execution); else pc<=pc+1 and go to FETCH.
- Latency:
  - ADD/SUB with result_ready=1: FETCH->DECODE->EXEC->WB, 4 cycles per instruction; result_valid rises 3 cycles after FETCH.
  - NON: 2 cycles, no result emitted.
- Arithmetic is performed by the ALU: modulo 2**DATA_W, carries discarded; SUB = A-B two's complement.
- start while busy is ignored. start in the same cycle as a HALT entry is not seen until the next cycle.
- result_ready asserted while result_valid=0 is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants NON/ADD/SUB/HLT
  - state encoding IDLE/FETCH/DECODE/EXEC/WB/HALT
  - instruction field bit positions
- The ALU and the datapath registers are not duplicated here; they are instantiated alongside this block at the top level.
- No sub-module: FSM, pc and ir live in one module.

Test Plan:
- Program {ADD 3,4; SUB 2,5; NON; HLT}, ready=1, start pulse -> results 4'h7 then 4'hD; no result for NON; done=1 and busy=0 after the HLT decode; err=0.
- Same program, result_ready held low 5 cycles on the first result -> result 4'h7 and valid stable all 5 cycles; the next FETCH (imem_addr=1) occurs only after the handshake.
- Program {ADD F,1; opcode 4'h5} -> result 4'h0 (wrap); err=1, done=1. A subsequent start clears err and restarts at imem_addr=0.
- 16 entries of ADD 1,1, no HLT -> 16 results of 4'h2, then HALT with err=0; imem_addr never wraps to 0.
- Assert rst low during WB with result_valid=1 -> all outputs return to reset values immediately (asynchronously); after release, state is IDLE until start.
- start pulsed mid-program while busy -> ignored; pc sequence and results unchanged.
